alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the ALU-control decoder: consumes its 4-bit ALU control code plus the two operands and computes the result.
- Registers the result, zero flag and compare flags into the EX/MEM boundary behind a valid/ready handshake.
- Uses a two-entry skid buffer, so memory-stage back-pressure never creates a combinational path from out_ready to in_ready.

Parameters:
- XLEN, 32, operand/result width (shift amount is always b[4:0]).
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous pipeline kill (branch mispredict/trap)
- in_valid  input  1  upstream holds a valid operation
- in_ready  output  1  stage can accept this cycle
- alu_ctl  input  4  ALU control code from the decoder
- op_a  input  XLEN  operand A (rs1/PC)
- op_b  input  XLEN  operand B (rs2/immediate)
- in_rd  input  RD_W  destination register
- in_reg_write  input  1  writeback enable
- out_valid  output  1  result entry valid
- out_ready  input  1  downstream accepts
- out_result  output  XLEN  ALU result
- out_zero  output  1  out_result == 0
- out_lt  output  1  signed op_a < op_b
- out_ltu  output  1  unsigned op_a < op_b
- out_rd  output  RD_W  registered in_rd
- out_reg_write  output  1  registered in_reg_write

Behaviour:
- Codes:
  - 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR.
  - 5 SLL a<<b[4:0], 6 SRL logical, 7 SRA arithmetic.
  - 8 SLT signed (result 1/0, zero-extended), 9 SLTU unsigned.
  - 10-15 behave as ADD.
- Arithmetic wraps modulo 2^XLEN; no overflow output.
- out_lt/out_ltu derive from operands irrespective of alu_ctl; out_zero derives from the computed result. All three are captured with the entry.
- Storage: main register M (drives outputs) and skid register S.
- Accept: in_valid & in_ready. Transfer: out_valid & out_ready.
- in_ready = !S.valid, driven from a flop only; no combinational dependence on out_ready.
- Latency: an entry accepted in cycle N appears at out_valid/out_result in cycle N+1 when M is free or drains in N.
- State (M.valid, S.valid) and transitions:
  - EMPTY (0,0): accept -> FULL1. Accepted data loads M.
  - FULL1 (1,0):
    - accept & transfer -> FULL1; new data loads M.
    - accept & !transfer -> FULL2; new data loads S.
    - transfer only -> EMPTY.
  - FULL2 (1,1): in_ready=0.
    - transfer -> FULL1; S moves to M.
    - no transfer -> hold.
- Outputs hold stable while out_valid & !out_ready. Order is strictly FIFO; no entry is lost or duplicated.
- flush (synchronous): clears M.valid and S.valid at the next edge, overriding any same-cycle accept (that input is dropped) and transfer. in_ready=1 the cycle after. Data fields need not clear.
- Reset (async, active-high): M.valid=S.valid=0, out_valid=0, in_ready=1. out_result=0, out_zero=0, out_lt=0, out_ltu=0, out_rd=0, out_reg_write=0. Reset mid-stream discards both entries.
- out_zero/out_lt/out_ltu/out_rd/out_reg_write are meaningful only when out_valid=1.

Test Plan:
- ADD/SUB: ctl=0, a=5, b=7 -> result 12, zero=0, valid next cycle. ctl=1, a=7, b=7 -> result 0, zero=1.
- Shifts/compares:
  - ctl=7, a=0x80000000, b=0x24 -> 0xF8000000 (shamt 4).
  - ctl=6, same operands -> 0x08000000.
  - ctl=8, a=0xFFFFFFFF, b=1 -> 1; ctl=9 -> 0; lt=1, ltu=0.
- Back-pressure: three back-to-back inputs (results 1, 2, 3) with out_ready=0 -> in_ready drops after the second accept, third held upstream. Release out_ready -> outputs 1, 2, 3 in order, no loss.
- Flush: FULL2 plus in_valid=1 and flush=1 -> next cycle out_valid=0, in_ready=1. The flushed input never appears.
- Reset mid-operation: assert rst asynchronously in FULL2 -> out_valid=0 and all outputs 0 immediately, in_ready=1. The first post-reset op (ctl=4, a=0xF0, b=0xFF -> 0x0F) is correct.
- Reserved code: ctl=12, a=3, b=4 -> result 7.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage fed by the ALU-control decoder.
// The ALU result is computed combinationally from the incoming operands.
// The result, together with the zero/compare flags and writeback info, is
// registered into the EX/MEM boundary.
// A two-entry skid buffer decouples the handshake:
//   M (main) drives the outputs; S (skid) catches one extra entry.
// Valid/ready semantics on both sides:
//   - a beat moves only when valid & ready are both high at a rising edge;
//   - a producer holds its payload stable while valid & !ready;
//   - in_ready is a flop (high exactly when S is empty), so out_ready never
//     reaches in_ready combinationally.
module alu_exec_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_reg_write,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_lt,
    output logic            out_ltu,
    output logic [RD_W-1:0] out_rd,
    output logic            out_reg_write
);

    // Width of one buffered entry: result, zero, lt, ltu, rd, reg_write.
    localparam int EW = XLEN + 3 + RD_W + 1;

    // Buffer occupancy: EMPTY (M and S free), FULL1 (M only), FULL2 (M and S).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL1 = 2'd1,
        ST_FULL2 = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic            cmp_lt;
    logic            cmp_ltu;
    logic            res_zero;
    logic [EW-1:0]   in_entry;
    logic [EW-1:0]   s_entry;
    logic            accept;
    logic            transfer;
    logic            load_m_in;
    logic            load_s_in;
    logic            move_s;

    // The shift amount is always the low five bits of operand B.
    assign shamt   = op_b[4:0];
    assign cmp_lt  = $signed(op_a) < $signed(op_b);
    assign cmp_ltu = op_a < op_b;

    // ALU function select; codes 10-15 fall back to ADD.
    always_comb begin
        alu_res = op_a + op_b;
        case (alu_ctl)
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = op_a << shamt;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $signed(op_a) >>> shamt;
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, cmp_lt};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, cmp_ltu};
            default: alu_res = op_a + op_b;
        endcase
    end

    assign res_zero = (alu_res == '0);
    assign in_entry = {alu_res, res_zero, cmp_lt, cmp_ltu, in_rd, in_reg_write};

    assign accept   = in_valid & in_ready;
    assign transfer = out_valid & out_ready;

    // A flush wins over every same-cycle accept and transfer.
    // The data registers are simply not loaded then; their contents are don't-care.
    assign load_m_in = !flush && accept &&
                       ((state == ST_EMPTY) || ((state == ST_FULL1) && transfer));
    assign load_s_in = !flush && accept && (state == ST_FULL1) && !transfer;
    assign move_s    = !flush && (state == ST_FULL2) && transfer;

    // Occupancy FSM with registered out_valid / in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state     <= ST_FULL1;
                        out_valid <= 1'b1;
                    end
                end
                ST_FULL1: begin
                    if (accept && !transfer) begin
                        state    <= ST_FULL2;
                        in_ready <= 1'b0;
                    end else if (!accept && transfer) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_FULL2: begin
                    if (transfer) begin
                        state    <= ST_FULL1;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Entry storage.
    // M takes new input directly, or the S entry when S drains forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result    <= '0;
            out_zero      <= 1'b0;
            out_lt        <= 1'b0;
            out_ltu       <= 1'b0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            s_entry       <= '0;
        end else begin
            if (load_m_in) begin
                {out_result, out_zero, out_lt, out_ltu, out_rd, out_reg_write} <= in_entry;
            end else if (move_s) begin
                {out_result, out_zero, out_lt, out_ltu, out_rd, out_reg_write} <= s_entry;
            end
            if (load_s_in) begin
                s_entry <= in_entry;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage.
// A driver pushes the hand-computed expected entry on every accept.
// A monitor pops and compares on every output transfer.
module tb_alu_exec_stage;

    localparam int XLEN = 32;
    localparam int RD_W = 5;
    localparam int EW   = XLEN + 3 + RD_W + 1;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [RD_W-1:0] in_rd;
    logic            in_reg_write;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic            out_lt;
    logic            out_ltu;
    logic [RD_W-1:0] out_rd;
    logic            out_reg_write;

    logic [EW-1:0] exp_q[$];
    int            n_tests;
    int            n_fail;
    int            tag;

    alu_exec_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_ctl      (alu_ctl),
        .op_a         (op_a),
        .op_b         (op_b),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_lt       (out_lt),
        .out_ltu      (out_ltu),
        .out_rd       (out_rd),
        .out_reg_write(out_reg_write)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        alu_ctl      = 4'd0;
        op_a         = '0;
        op_b         = '0;
        in_rd        = '0;
        in_reg_write = 1'b0;
    endtask

    // Presents one op and waits (bounded) for it to be accepted.
    // Returns at #1 after the accepting edge, with in_valid still high.
    task automatic send(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic z, input logic lt, input logic ltu);
        int cyc;
        logic [RD_W-1:0] rd;
        logic rw;
        tag++;
        rd = tag[RD_W-1:0];
        rw = tag[0];
        in_valid     = 1'b1;
        alu_ctl      = ctl;
        op_a         = a;
        op_b         = b;
        in_rd        = rd;
        in_reg_write = rw;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd1, 64'd0);
            return;
        end
        exp_q.push_back({res, z, lt, ltu, rd, rw});
        @(posedge clk);
        #1;
        check("latency_out_valid", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic drain(input int max_cyc);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    // Inputs change only just after rising edges, so at the falling edge
    // out_valid & out_ready tell us exactly which beat transfers next edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {23'd0, out_result, out_zero, out_lt, out_ltu,
                                            out_rd, out_reg_write}, 64'd0);
            end else begin
                check("scoreboard_entry",
                      {23'd0, out_result, out_zero, out_lt, out_ltu, out_rd, out_reg_write},
                      {23'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_tests   = 0;
        n_fail    = 0;
        tag       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_outputs", {23'd0, out_result, out_zero, out_lt, out_ltu, out_rd,
                                out_reg_write}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic function vectors, downstream always ready.
        out_ready = 1'b1;
        send(4'd0,  32'd5,          32'd7,          32'd12,         1'b0, 1'b1, 1'b1);
        send(4'd1,  32'd7,          32'd7,          32'd0,          1'b1, 1'b0, 1'b0);
        send(4'd7,  32'h8000_0000,  32'h24,         32'hF800_0000,  1'b0, 1'b1, 1'b0);
        send(4'd6,  32'h8000_0000,  32'h24,         32'h0800_0000,  1'b0, 1'b1, 1'b0);
        send(4'd8,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b1, 1'b0);
        send(4'd9,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1, 1'b0);
        send(4'd2,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b1, 1'b1);
        send(4'd3,  32'd1,          32'd2,          32'd3,          1'b0, 1'b1, 1'b1);
        send(4'd4,  32'h0000_00F0,  32'h0000_00F0,  32'd0,          1'b1, 1'b0, 1'b0);
        send(4'd5,  32'd1,          32'h21,         32'd2,          1'b0, 1'b1, 1'b1);
        send(4'd12, 32'd3,          32'd4,          32'd7,          1'b0, 1'b1, 1'b1);
        send(4'd15, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1, 1'b0);
        idle();
        drain(20);

        // Back-pressure: three back-to-back ops with the sink stalled.
        out_ready = 1'b0;
        send(4'd0, 32'd0, 32'd1, 32'd1, 1'b0, 1'b1, 1'b1);
        check("bp_in_ready_after_first", {63'd0, in_ready}, 64'd1);
        send(4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        check("bp_in_ready_after_second", {63'd0, in_ready}, 64'd0);
        fork
            send(4'd0, 32'd2, 32'd1, 32'd3, 1'b0, 1'b0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #2;
                check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
                check("bp_hold_result", {32'd0, out_result}, 64'd1);
                check("bp_still_blocked", {63'd0, in_ready}, 64'd0);
                out_ready = 1'b1;
            end
        join
        idle();
        drain(20);

        // Flush while FULL2 with a same-cycle input that must be dropped.
        out_ready = 1'b0;
        send(4'd0, 32'd10, 32'd1, 32'd11, 1'b0, 1'b0, 1'b0);
        send(4'd0, 32'd20, 32'd1, 32'd21, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        op_a     = 32'd99;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle();
        exp_q.delete();
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset in FULL2, asserted away from any clock edge.
        out_ready = 1'b0;
        send(4'd0, 32'd30, 32'd1, 32'd31, 1'b0, 1'b0, 1'b0);
        send(4'd0, 32'd40, 32'd1, 32'd41, 1'b0, 1'b0, 1'b0);
        idle();
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("async_rst_outputs", {23'd0, out_result, out_zero, out_lt, out_ltu, out_rd,
                                    out_reg_write}, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'd4, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b0, 1'b1, 1'b1);
        idle();
        drain(20);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
